// File: rtl/score_display_if.sv
// Score-in / display-out bundle between the board top (master) and the score display (slave).
interface score_display_if;
    logic [15:0] score;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic        busy;

    modport master (output score, input seg, an, dp, busy);
    modport slave  (input score, output seg, an, dp, busy);
endinterface

// File: rtl/score_display.sv
// Converts a 16-bit score to BCD with a sequential double-dabble engine and scans it
// onto an active-low multiplexed seven-segment display with leading-zero blanking.
module score_display #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic           clk,
    input  logic           reset,
    score_display_if.slave bus
);
    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BcdW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    state_e          state_q, state_d;
    logic [15:0]     last_score_q, last_score_d;
    logic [15:0]     bin_q, bin_d;
    logic [BcdW-1:0] acc_q, acc_d;
    logic [BcdW-1:0] disp_q, disp_d;
    logic [3:0]      iter_q, iter_d;
    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [7:0]      an_q, an_d;
    logic [BcdW-1:0] acc_adj;
    logic [3:0]      digit;
    logic            blank;

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        bin_d        = bin_q;
        acc_d        = acc_q;
        disp_d       = disp_q;
        iter_d       = iter_q;
        busy_d       = busy_q;
        acc_adj      = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            StIdle: begin
                if (bus.score != last_score_q) begin
                    bin_d        = bus.score;
                    last_score_d = bus.score;
                    acc_d        = '0;
                    iter_d       = '0;
                    busy_d       = 1'b1;
                    state_d      = StShift;
                end
            end
            StShift: begin
                {acc_d, bin_d} = {acc_adj[BcdW-2:0], bin_q, 1'b0};
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd15) state_d = StLatch;
            end
            StLatch: begin
                disp_d  = acc_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // an/seg are built from the next index and next display value so they change together.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        an_d  = ~(8'd1 << idx_d);
        digit = '0;
        blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                digit = disp_d[4*i +: 4];
                blank = (i != 0) && ((disp_d >> (4 * i)) == '0);
            end
        end
        case (digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
        if (blank) seg_d = 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_score_q <= '0;
            bin_q        <= '0;
            acc_q        <= '0;
            disp_q       <= '0;
            iter_q       <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= 7'b1000000;
            an_q         <= 8'hFE;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            disp_q       <= disp_d;
            iter_q       <= iter_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = busy_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bcd_chk
        a_bcd_legal: assert property (@(posedge clk) disable iff (reset)
            disp_q[4*g +: 4] <= 4'd9);
    end
endmodule

// File: tb/tb_score_display.sv
// Randomised bench for score_display: an arithmetic reference model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_score_display;
    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned NUM_DIGITS = 5;

    typedef struct packed {
        logic       busy;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    score_display_if bus ();

    score_display #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] seg_tab[10];
    int         p10[5];

    // Model state: score last accepted, value in flight, shown value, cycles left busy,
    // and cycles since the last reset edge.
    int m_last, m_pend, m_disp, m_timer, m_tick;
    bit started = 0;

    function automatic exp_t model_out();
        exp_t e;
        int   idx;
        int   d;
        idx    = (m_tick / SCAN_DIV) % NUM_DIGITS;
        d      = (m_disp / p10[idx]) % 10;
        e.busy = (m_timer != 0);
        e.an   = ~(8'd1 << idx);
        e.seg  = (idx != 0 && m_disp < p10[idx]) ? 7'b1111111 : seg_tab[d];
        e.dp   = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the inputs the DUT also sampled.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_last  = 0;
                m_pend  = 0;
                m_disp  = 0;
                m_timer = 0;
                m_tick  = 0;
                started = 1;
            end else if (started) begin
                m_tick++;
                if (m_timer == 0) begin
                    if (int'(bus.score) != m_last) begin
                        m_last  = int'(bus.score);
                        m_pend  = int'(bus.score);
                        m_timer = 17;
                    end
                end else begin
                    m_timer--;
                    if (m_timer == 0) m_disp = m_pend;
                end
            end
            if (started) exp_q.push_back(model_out());
        end
    end

    // Monitor: the DUT presents a new output set every cycle; compare it mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("busy", 16'(bus.busy), 16'(e.busy));
                check("an",   16'(bus.an),   16'(e.an));
                check("seg",  16'(bus.seg),  16'(e.seg));
                check("dp",   16'(bus.dp),   16'(e.dp));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pick;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        p10     = '{1, 10, 100, 1000, 10000};
        reset     = 1'b1;
        bus.score = '0;
        cyc(3);
        reset = 1'b0;
        cyc(30);
        bus.score = 16'd12345; cyc(45);
        bus.score = 16'd65535; cyc(45);
        bus.score = 16'd9;     cyc(45);
        bus.score = 16'd100;   cyc(45);
        bus.score = 16'd500;   cyc(5);
        bus.score = 16'd777;   cyc(60);
        bus.score = 16'd4321;  cyc(8);
        reset = 1'b1; cyc(1);
        reset = 1'b0; cyc(45);
        cyc(1000);
        // Score changing every cycle stresses changes that land mid-conversion.
        for (int i = 0; i < 40; i++) begin
            bus.score = 16'($urandom);
            cyc(1);
        end
        for (int i = 0; i < 150; i++) begin
            pick = int'($urandom_range(0, 7));
            case (pick)
                0:       bus.score = 16'd0;
                1:       bus.score = 16'd65535;
                2:       bus.score = 16'($urandom_range(0, 9));
                3:       bus.score = 16'($urandom_range(10, 999));
                default: bus.score = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) begin
                cyc(int'($urandom_range(1, 17)));
                reset = 1'b1;
                cyc(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            cyc(int'($urandom_range(1, 30)));
        end
        cyc(45);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/score_display.md
Name: score_display

Overview:
Downstream consumer of the processor score on the FPGA board top. Takes the low 16 bits of the game score and converts them to 5 BCD digits with a sequential double-dabble engine. It drives a time-multiplexed, active-low 8-digit seven-segment display with leading-zero blanking. It runs on the 100 MHz board clock, not on the divided processor or game clocks.

Parameters:
SCAN_DIV, 100000, board clk cycles each digit is lit (1 kHz per digit at 100 MHz); legal range >= 2
NUM_DIGITS, 5, digits scanned (fixed at 5 for a 16-bit score; 65535 max)

Ports:
clk  input  1  board clock (100 MHz)
reset  input  1  synchronous, active-high reset
score  input  16  binary score, low half of processor score; may change on any cycle
seg  output  7  segments {g,f,e,d,c,b,a}, active low
an  output  8  digit anodes, active low; bit i = digit i, digit 0 = least significant
dp  output  1  decimal point, active low; always 1 (off)
busy  output  1  high while a conversion is in progress

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: seg=7'b1000000 ("0"), an=8'hFE, dp=1, busy=0, display BCD=0, last_score=0, scan index=0, scan counter=0, FSM=IDLE.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: if score != last_score, then:
  - capture score into the shift register and last_score,
  - clear the BCD accumulator, set iteration count=0, busy<=1,
  - go to SHIFT.
  Otherwise stay in IDLE.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
  - Exactly 16 SHIFT cycles; after the 16th go to LATCH.
  - BCD accumulator is 20 bits (5 nibbles).
- LATCH: copy the accumulator into the display BCD register, busy<=0, return to IDLE.
- Latency: score change seen at cycle N; the new value is visible in the display register at cycle N+18. busy is high for cycles N+1..N+17.
- A score change during SHIFT/LATCH does not disturb the current conversion. On return to IDLE, a compare against last_score starts a new conversion. Display never shows a partial result.
- Reset mid-conversion: abort immediately, all state goes to reset values, display shows "0".
- Scan counter: counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the scan index advances 0,1,..,NUM_DIGITS-1, then wraps to 0.
- an: bit [index] low and all other bits high. Bits 7..5 are never low.
- seg encodes display digit [index], decoded as:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- seg and an update in the same cycle.
- Leading-zero blanking: digit i (i>=1) shows seg=1111111 when it and all higher digits are zero. Digit 0 is never blanked. Blanking uses only the display register, never the in-flight accumulator.
- BCD nibbles never exceed 9. There are no illegal codes: a nibble >9 is an RTL error and is caught by an assertion.

Test Plan:
- Bench uses SCAN_DIV=4.
- Reset: assert reset 3 cycles with score=0 -> an=FE, seg=1000000, busy=0. After release, an walks FE,FD,FB,F7,EF every 4 cycles, then back to FE. Digits 1-4 show 1111111.
- Conversion: score 0->12345 at cycle N -> busy high N+1..N+17; display BCD=0x12345 at N+18. Scanned seg values: digit0=0010010 (5), d1=0011001 (4), d2=0110000 (3), d3=0100100 (2), d4=1111001 (1).
- Boundary values: score=65535 -> digits 5,3,5,5,6, no blanking. Score=9 -> digit0=0010000, d1..d4 blank. Score=100 -> d0=d1=1000000 (zero, not blank), d2=1111001, d3,d4 blank.
- Change mid-conversion: score=500 then 777 five cycles later -> display shows 500 first. 777 is displayed 18 cycles after the first conversion ends. No other intermediate display value occurs.
- Reset mid-conversion: score=4321, reset at cycle N+8 -> busy=0, display 0. After release, score still 4321 != last_score (0) -> reconverts, 4321 appears 18 cycles after release.
- Steady input: score held constant 1000 cycles after conversion -> busy stays 0, no re-conversion, an/seg scan pattern periodic with period 20 cycles.
